// File: rtl/axis_hdr_pkg.sv
// Shared types and keep/count helpers for the multi-beat header inserter.
// Helpers operate on 64-lane vectors so one definition serves every bus width.
package axis_hdr_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StData,
        StFlush
    } hdr_state_t;

    localparam int unsigned MaxBytes = 64;

    function automatic logic [7:0] keep_to_cnt(input logic [MaxBytes-1:0] keep);
        logic [7:0] cnt;
        cnt = '0;
        for (int i = 0; i < MaxBytes; i++) begin
            cnt = cnt + {7'd0, keep[i]};
        end
        return cnt;
    endfunction

    function automatic logic [MaxBytes-1:0] cnt_to_keep_left(input logic [7:0] cnt,
                                                             input logic [7:0] nb);
        logic [MaxBytes-1:0] keep;
        keep = '0;
        for (int i = 0; i < MaxBytes; i++) begin
            if (i < int'(nb)) begin
                keep[int'(nb) - 1 - i] = (i < int'(cnt));
            end
        end
        return keep;
    endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// Residue register plus append shifter: accumulates MSB-first bytes and
// emits a full beat whenever the residue plus the new bytes reach a bus width.
module axis_byte_packer #(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WD-1:0]     i_bytes,
    input  logic [BYTE_CNT_WD:0]   i_cnt,
    input  logic                   i_lsb_aligned,
    input  logic                   i_push,
    input  logic                   i_flush,
    output logic [DATA_WD-1:0]     o_beat,
    output logic                   o_emit,
    output logic [DATA_WD-1:0]     o_res,
    output logic [BYTE_CNT_WD-1:0] o_res_cnt,
    output logic [BYTE_CNT_WD-1:0] o_next_cnt
);

    localparam int unsigned CW = BYTE_CNT_WD;
    localparam logic [CW+1:0] NbSh = (CW + 2)'(DATA_BYTE_WD);
    localparam logic [CW:0]   NbT  = (CW + 1)'(DATA_BYTE_WD);
    localparam logic [CW-1:0] NbLo = CW'(DATA_BYTE_WD);

    logic [DATA_WD-1:0]   r_res;
    logic [CW-1:0]        r_cnt;
    logic [CW+1:0]        w_sh;
    logic [3*DATA_WD-1:0] w_shifted;
    logic [2*DATA_WD-1:0] w_cat;
    logic [CW:0]          w_t;
    logic                 w_full;

    // Source sits in the middle third; a single left shift puts its first byte at lane r,
    // whether it arrives MSB-aligned (data) or LSB-aligned (header).
    assign w_sh      = (i_lsb_aligned ? (NbSh + NbSh - {1'b0, i_cnt}) : NbSh) - {2'b00, r_cnt};
    assign w_shifted = {{DATA_WD{1'b0}}, i_bytes, {DATA_WD{1'b0}}} << {w_sh, 3'b000};
    assign w_cat     = {r_res, {DATA_WD{1'b0}}} | w_shifted[3*DATA_WD-1:DATA_WD];

    assign w_t        = {1'b0, r_cnt} + i_cnt;
    assign w_full     = (w_t >= NbT);
    assign o_next_cnt = w_full ? (w_t[CW-1:0] - NbLo) : w_t[CW-1:0];
    assign o_emit     = i_push && w_full;
    assign o_beat     = w_cat[2*DATA_WD-1:DATA_WD];
    assign o_res      = r_res;
    assign o_res_cnt  = r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_res <= '0;
            r_cnt <= '0;
        end else if (i_push) begin
            r_res <= w_full ? w_cat[DATA_WD-1:0] : w_cat[2*DATA_WD-1:DATA_WD];
            r_cnt <= o_next_cnt;
        end
    end

endmodule

// File: rtl/axi_stream_insert_header_mb.sv
// Prepends a multi-beat header stream to each data packet and repacks the joined
// byte stream into dense MSB-first beats behind a single output register.
module axi_stream_insert_header_mb
    import axis_hdr_pkg::*;
#(
    parameter int unsigned DATA_WD      = 32,
    parameter int unsigned DATA_BYTE_WD = DATA_WD / 8,
    parameter int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int unsigned CNT_WD       = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic                    last_insert,
    output logic                    ready_insert,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic [CNT_WD-1:0]       pkt_cnt
);

    localparam int unsigned CW = BYTE_CNT_WD;

    hdr_state_t r_state, w_state_d;

    logic                    r_valid, r_last;
    logic [DATA_WD-1:0]      r_data;
    logic [DATA_BYTE_WD-1:0] r_keep;
    logic [CNT_WD-1:0]       r_pkt_cnt;

    logic                    w_valid_d, w_last_d;
    logic [DATA_WD-1:0]      w_data_d;
    logic [DATA_BYTE_WD-1:0] w_keep_d;

    logic                    w_adv, w_adv_g;
    logic [7:0]              w_ins_cnt8, w_dat_cnt8;
    logic [63:0]             w_res_keep64;
    logic [CW:0]             w_ins_cnt, w_dat_cnt, w_pk_cnt;
    logic [DATA_WD-1:0]      w_ins_bytes, w_dat_bytes, w_pk_bytes;
    logic                    w_lsb, w_push, w_flush, w_emit;
    logic [DATA_WD-1:0]      w_beat, w_res;
    logic [CW-1:0]           w_res_cnt, w_next_cnt;
    logic [DATA_BYTE_WD-1:0] w_res_keep;
    logic                    w_unused;

    // Readies are forced low while reset is held so every output reads 0.
    assign w_adv   = !r_valid || ready_out;
    assign w_adv_g = w_adv && rst_n;

    assign w_ins_cnt8   = keep_to_cnt(64'(keep_insert));
    assign w_dat_cnt8   = keep_to_cnt(64'(keep_in));
    assign w_ins_cnt    = w_ins_cnt8[CW:0];
    assign w_dat_cnt    = w_dat_cnt8[CW:0];
    assign w_res_keep64 = cnt_to_keep_left(8'(w_res_cnt), 8'(DATA_BYTE_WD));
    assign w_res_keep   = w_res_keep64[DATA_BYTE_WD-1:0];
    assign w_unused     = ^{w_ins_cnt8, w_dat_cnt8, w_res_keep64};

    always_comb begin
        w_ins_bytes = '0;
        w_dat_bytes = '0;
        for (int i = 0; i < int'(DATA_BYTE_WD); i++) begin
            w_ins_bytes[8*i +: 8] = data_insert[8*i +: 8] & {8{keep_insert[i]}};
            w_dat_bytes[8*i +: 8] = data_in[8*i +: 8] & {8{keep_in[i]}};
        end
    end

    axis_byte_packer #(
        .DATA_WD      (DATA_WD),
        .DATA_BYTE_WD (DATA_BYTE_WD),
        .BYTE_CNT_WD  (BYTE_CNT_WD)
    ) u_packer (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_bytes       (w_pk_bytes),
        .i_cnt         (w_pk_cnt),
        .i_lsb_aligned (w_lsb),
        .i_push        (w_push),
        .i_flush       (w_flush),
        .o_beat        (w_beat),
        .o_emit        (w_emit),
        .o_res         (w_res),
        .o_res_cnt     (w_res_cnt),
        .o_next_cnt    (w_next_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle, StHdr: begin
                if (valid_insert && w_adv_g) begin
                    w_state_d = last_insert ? StData : StHdr;
                end
            end
            StData: begin
                if (valid_in && w_adv_g && last_in) begin
                    w_state_d = (w_next_cnt == '0) ? StIdle : StFlush;
                end
            end
            StFlush: begin
                if (w_adv_g) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_insert = 1'b0;
        ready_in     = 1'b0;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        w_lsb        = 1'b0;
        w_pk_bytes   = w_dat_bytes;
        w_pk_cnt     = w_dat_cnt;
        w_valid_d    = w_adv ? 1'b0 : r_valid;
        w_data_d     = r_data;
        w_keep_d     = r_keep;
        w_last_d     = r_last;
        unique case (r_state)
            StIdle, StHdr: begin
                ready_insert = w_adv_g;
                w_lsb        = 1'b1;
                w_pk_bytes   = w_ins_bytes;
                w_pk_cnt     = w_ins_cnt;
                w_push       = valid_insert && w_adv_g;
                if (w_emit) begin
                    w_valid_d = 1'b1;
                    w_data_d  = w_beat;
                    w_keep_d  = '1;
                    w_last_d  = 1'b0;
                end
            end
            StData: begin
                ready_in = w_adv_g;
                w_push   = valid_in && w_adv_g;
                if (w_emit) begin
                    w_valid_d = 1'b1;
                    w_data_d  = w_beat;
                    w_keep_d  = '1;
                    w_last_d  = last_in && (w_next_cnt == '0);
                end else if (w_push && last_in && (w_next_cnt == '0)) begin
                    // Empty last beat with nothing buffered: close the packet with an empty beat.
                    w_valid_d = 1'b1;
                    w_data_d  = '0;
                    w_keep_d  = '0;
                    w_last_d  = 1'b1;
                end
            end
            StFlush: begin
                if (w_adv_g) begin
                    w_flush   = 1'b1;
                    w_valid_d = 1'b1;
                    w_data_d  = w_res;
                    w_keep_d  = w_res_keep;
                    w_last_d  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_keep    <= '0;
            r_last    <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            r_valid <= w_valid_d;
            r_data  <= w_data_d;
            r_keep  <= w_keep_d;
            r_last  <= w_last_d;
            if (r_valid && ready_out && r_last) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    assign valid_out = r_valid;
    assign data_out  = r_data;
    assign keep_out  = r_keep;
    assign last_out  = r_last;
    assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_axi_stream_insert_header_mb.sv
// Directed bench for the multi-beat header inserter at DATA_WD=32; a second
// instance with a 2-bit packet counter shares the stimulus to exercise wrap.
module tb_axi_stream_insert_header_mb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, last_in, valid_insert, last_insert, ready_out;
    logic [31:0] data_in, data_insert;
    logic [3:0]  keep_in, keep_insert;

    logic        ready_in, ready_insert, valid_out, last_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic [15:0] pkt_cnt;

    logic        ready_in2, ready_insert2, valid_out2, last_out2;
    logic [31:0] data_out2;
    logic [3:0]  keep_out2;
    logic [1:0]  pkt_cnt2;

    int          checks = 0;
    int          errors = 0;
    logic [36:0] q_beat[$];
    logic [1:0]  q_cnt2[$];
    logic [1:0]  prev_cnt2 = 2'd0;
    bit          rnd_ready = 1'b0;

    always #5 clk = ~clk;

    axi_stream_insert_header_mb #(.DATA_WD(32), .CNT_WD(16)) u_dut (
        .clk (clk), .rst_n (rst_n),
        .valid_in (valid_in), .data_in (data_in), .keep_in (keep_in), .last_in (last_in),
        .ready_in (ready_in),
        .valid_insert (valid_insert), .data_insert (data_insert), .keep_insert (keep_insert),
        .last_insert (last_insert), .ready_insert (ready_insert),
        .valid_out (valid_out), .data_out (data_out), .keep_out (keep_out),
        .last_out (last_out), .ready_out (ready_out), .pkt_cnt (pkt_cnt)
    );

    axi_stream_insert_header_mb #(.DATA_WD(32), .CNT_WD(2)) u_dut2 (
        .clk (clk), .rst_n (rst_n),
        .valid_in (valid_in), .data_in (data_in), .keep_in (keep_in), .last_in (last_in),
        .ready_in (ready_in2),
        .valid_insert (valid_insert), .data_insert (data_insert), .keep_insert (keep_insert),
        .last_insert (last_insert), .ready_insert (ready_insert2),
        .valid_out (valid_out2), .data_out (data_out2), .keep_out (keep_out2),
        .last_out (last_out2), .ready_out (ready_out), .pkt_cnt (pkt_cnt2)
    );

    // Output handshakes complete on the following posedge; inputs only move at posedge+1.
    always @(negedge clk) begin
        if (valid_out && ready_out) q_beat.push_back({last_out, keep_out, data_out});
        if (pkt_cnt2 !== prev_cnt2) begin
            q_cnt2.push_back(pkt_cnt2);
            prev_cnt2 = pkt_cnt2;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) ready_out = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put_hdr(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        valid_insert = 1'b1; data_insert = d; keep_insert = k; last_insert = l;
        @(negedge clk);
        while (!ready_insert && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hdr_accept", 64'(ready_insert), 64'(1'b1));
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
    endtask

    task automatic put_dat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
        @(negedge clk);
        while (!ready_in && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("dat_accept", 64'(ready_in), 64'(1'b1));
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        int t = 0;
        while (q_beat.size() < n && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk(tag, 64'(q_beat.size()), 64'(n));
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
        logic [36:0] obs;
        obs = (i < q_beat.size()) ? q_beat[i] : 'x;
        chk(tag, 64'(obs), 64'({l, k, d}));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ready_out = 1'b1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; keep_insert = '0; last_insert = 1'b0;
        #2;
        chk("rst_valid", 64'(valid_out), 64'(1'b0));
        chk("rst_data", 64'(data_out), 64'(32'h0));
        chk("rst_keep", 64'(keep_out), 64'(4'h0));
        chk("rst_last", 64'(last_out), 64'(1'b0));
        chk("rst_ready_in", 64'(ready_in), 64'(1'b0));
        chk("rst_ready_insert", 64'(ready_insert), 64'(1'b0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(16'h0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("idle_ready_insert", 64'(ready_insert), 64'(1'b1));
        chk("idle_ready_in", 64'(ready_in), 64'(1'b0));
        @(posedge clk); #1;

        // Scenario 1: two-byte header, full then half data beat, no flush
        put_hdr(32'h0000_1122, 4'b0011, 1'b1);
        put_dat(32'hA0A1_A2A3, 4'b1111, 1'b0);
        put_dat(32'hB0B1_B2B3, 4'b1100, 1'b1);
        wait_beats("s1_count", 2);
        chk_beat("s1_b0", 0, 32'h1122_A0A1, 4'b1111, 1'b0);
        chk_beat("s1_b1", 1, 32'hA2A3_B0B1, 4'b1111, 1'b1);
        chk("s1_pkt_cnt", 64'(pkt_cnt), 64'(16'd1));
        q_beat.delete();

        // Scenario 2: one-byte header, residue drains in FLUSH
        put_hdr(32'h0000_0033, 4'b0001, 1'b1);
        put_dat(32'hC0C1_C2C3, 4'b1111, 1'b1);
        wait_beats("s2_count", 2);
        chk_beat("s2_b0", 0, 32'h33C0_C1C2, 4'b1111, 1'b0);
        chk_beat("s2_b1", 1, 32'hC300_0000, 4'b1000, 1'b1);
        chk("s2_pkt_cnt", 64'(pkt_cnt), 64'(16'd2));
        q_beat.delete();

        // Scenario 3: two header beats, three-byte last data beat
        put_hdr(32'h0000_0044, 4'b0001, 1'b0);
        put_hdr(32'h5566_7788, 4'b1111, 1'b1);
        put_dat(32'hD0D1_D2D3, 4'b1110, 1'b1);
        wait_beats("s3_count", 2);
        chk_beat("s3_b0", 0, 32'h4455_6677, 4'b1111, 1'b0);
        chk_beat("s3_b1", 1, 32'h88D0_D1D2, 4'b1111, 1'b1);
        chk("s3_pkt_cnt", 64'(pkt_cnt), 64'(16'd3));
        q_beat.delete();

        // Scenario 4: aligned pass-through with a 10-cycle downstream stall
        put_hdr(32'h0102_0304, 4'b1111, 1'b1);
        put_dat(32'hE0E1_E2E3, 4'b1111, 1'b0);
        ready_out = 1'b0;
        valid_in = 1'b1; data_in = 32'hF0F1_F2F3; keep_in = 4'b1111; last_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("s4_hold_data", 64'(data_out), 64'(32'hE0E1_E2E3));
            chk("s4_hold_valid", 64'(valid_out), 64'(1'b1));
            chk("s4_hold_ready_in", 64'(ready_in), 64'(1'b0));
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
        put_dat(32'hF0F1_F2F3, 4'b1111, 1'b0);
        put_dat(32'h9091_9293, 4'b1111, 1'b1);
        wait_beats("s4_count", 4);
        chk_beat("s4_b0", 0, 32'h0102_0304, 4'b1111, 1'b0);
        chk_beat("s4_b1", 1, 32'hE0E1_E2E3, 4'b1111, 1'b0);
        chk_beat("s4_b2", 2, 32'hF0F1_F2F3, 4'b1111, 1'b0);
        chk_beat("s4_b3", 3, 32'h9091_9293, 4'b1111, 1'b1);
        chk("s4_pkt_cnt", 64'(pkt_cnt), 64'(16'd4));
        q_beat.delete();

        // Scenario 5: reset mid-packet discards the in-flight beat
        put_hdr(32'h0000_1122, 4'b0011, 1'b1);
        put_dat(32'hA0A1_A2A3, 4'b1111, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("s5_valid", 64'(valid_out), 64'(1'b0));
        chk("s5_data", 64'(data_out), 64'(32'h0));
        chk("s5_keep", 64'(keep_out), 64'(4'h0));
        chk("s5_last", 64'(last_out), 64'(1'b0));
        chk("s5_ready_in", 64'(ready_in), 64'(1'b0));
        chk("s5_ready_insert", 64'(ready_insert), 64'(1'b0));
        chk("s5_pkt_cnt", 64'(pkt_cnt), 64'(16'd0));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("s5_no_beat", 64'(q_beat.size()), 64'(0));
        put_hdr(32'h0000_1122, 4'b0011, 1'b1);
        put_dat(32'hA0A1_A2A3, 4'b1111, 1'b0);
        put_dat(32'hB0B1_B2B3, 4'b1100, 1'b1);
        wait_beats("s5_count", 2);
        chk_beat("s5_b0", 0, 32'h1122_A0A1, 4'b1111, 1'b0);
        chk_beat("s5_b1", 1, 32'hA2A3_B0B1, 4'b1111, 1'b1);
        chk("s5_pkt_cnt_after", 64'(pkt_cnt), 64'(16'd1));

        // Scenario 6: five scenario-2 packets with random gaps; 2-bit counter wraps
        pulse_reset();
        q_beat.delete();
        q_cnt2.delete();
        rnd_ready = 1'b1;
        for (int p = 0; p < 5; p++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            put_hdr(32'h0000_0033, 4'b0001, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            put_dat(32'hC0C1_C2C3, 4'b1111, 1'b1);
        end
        wait_beats("s6_count", 10);
        for (int p = 0; p < 5; p++) begin
            chk_beat("s6_full", 2 * p, 32'h33C0_C1C2, 4'b1111, 1'b0);
            chk_beat("s6_flush", 2 * p + 1, 32'hC300_0000, 4'b1000, 1'b1);
        end
        chk("s6_cnt2_len", 64'(q_cnt2.size()), 64'(5));
        for (int p = 0; p < 5; p++) begin
            logic [1:0] obs;
            obs = (p < q_cnt2.size()) ? q_cnt2[p] : 'x;
            chk("s6_cnt2_seq", 64'(obs), 64'((p + 1) % 4));
        end
        chk("s6_pkt_cnt", 64'(pkt_cnt), 64'(16'd5));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
